frame_capture_sink: RTL and testbench

FRAME_CAPTURE_SINK -- requirements
Module: frame_capture_sink

---
 rtl/frame_capture_sink_pkg.sv | 18 +
 rtl/frame_bank_ram.sv | 34 +++
 rtl/frame_capture_sink.sv | 172 +++++++++++++++++
 tb/tb_frame_capture_sink.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_capture_sink_pkg.sv
// Shared fixed-point defaults and FSM state encoding for the frame capture sink.
package frame_capture_sink_pkg;

  // Default sample format: signed Q(WI.WF)
  localparam int WI_DEFAULT   = 12;
  localparam int WF_DEFAULT   = 12;
  // Default frame length in samples (power of two, at least 4)
  localparam int WINS_DEFAULT = 1024;

  // Capture FSM: FILL accepts samples, SWAP is the single dead cycle between
  // frames, STALL waits for the host to release the held frame.
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_SWAP  = 2'd1,
    ST_STALL = 2'd2
  } fcs_state_e;

endpackage

// File: rtl/frame_bank_ram.sv
// One frame bank: synchronous write port plus registered read port.
module frame_bank_ram #(
  parameter int DW    = 24,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Array write; contents are not reset so the array maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: loads only on a read strobe, otherwise holds the last word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= {DW{1'b0}};
    end else if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/frame_capture_sink.sv
// Ping-pong frame capture sink with peak tracking and a host read port.
module frame_capture_sink
  import frame_capture_sink_pkg::*;
#(
  parameter int WI   = WI_DEFAULT,
  parameter int WF   = WF_DEFAULT,
  parameter int winS = WINS_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic signed [WI+WF-1:0]  in,
  input  logic                     Valid_in,
  output logic                     Ready_in,
  input  logic                     rd_en,
  input  logic [$clog2(winS)-1:0]  rd_addr,
  output logic signed [WI+WF-1:0]  rd_data,
  input  logic                     buf_release,
  output logic                     frame_done,
  output logic [WI+WF-1:0]         peak_val,
  output logic [$clog2(winS)-1:0]  peak_idx,
  output logic [15:0]              frame_cnt
);

  localparam int W  = WI + WF;
  localparam int AW = $clog2(winS);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};

  fcs_state_e      state_q;
  logic            ready_q;
  logic            held_q;
  logic            done_q;
  logic            wr_bank_q;   // bank being filled; the other bank is held
  logic            rd_sel_q;    // bank whose read register drives rd_data
  logic [15:0]     frame_cnt_q;
  logic [W-1:0]    peak_val_q;
  logic [AW-1:0]   peak_idx_q;
  logic [W-1:0]    run_val_q;
  logic [AW-1:0]   run_idx_q;
  logic [AW-1:0]   wr_cnt_q;

  logic            xfer;
  logic            last_xfer;
  logic            swap_go;
  logic [W-1:0]    mag;
  logic [1:0]      bank_we;
  logic [1:0]      bank_re;
  logic [W-1:0]    bank_rdata [2];

  assign xfer      = Valid_in && ready_q;
  assign last_xfer = xfer && (&wr_cnt_q);
  // A swap happens leaving SWAP when the held slot is free (or freed now),
  // or leaving STALL once the host releases the held frame.
  assign swap_go   = ((state_q == ST_SWAP) && (!held_q || buf_release)) ||
                     ((state_q == ST_STALL) && buf_release);

  // Saturating magnitude: the most negative code has no positive twin
  always_comb begin
    if (in == MOST_NEG) begin
      mag = MAX_POS;
    end else if (in[W-1]) begin
      mag = $unsigned(-in);
    end else begin
      mag = $unsigned(in);
    end
  end

  // Write address counter; wraps naturally because winS is a power of two
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_cnt_q <= {AW{1'b0}};
    end else if (xfer) begin
      wr_cnt_q <= wr_cnt_q + AW'(1);
    end
  end

  // Running peak of the frame being filled; sample 0 restarts it, ties keep the first index
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      run_val_q <= {W{1'b0}};
      run_idx_q <= {AW{1'b0}};
    end else if (xfer && ((wr_cnt_q == {AW{1'b0}}) || (mag > run_val_q))) begin
      run_val_q <= mag;
      run_idx_q <= wr_cnt_q;
    end
  end

  // Capture FSM with registered Ready_in, held flag, swap side effects and frame outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_FILL;
      ready_q     <= 1'b0;
      held_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_bank_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
      peak_val_q  <= {W{1'b0}};
      peak_idx_q  <= {AW{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          if (buf_release) begin
            held_q <= 1'b0;
          end
          if (last_xfer) begin
            state_q <= ST_SWAP;
            ready_q <= 1'b0;
          end else begin
            state_q <= ST_FILL;
            ready_q <= 1'b1;
          end
        end
        ST_SWAP, ST_STALL: begin
          if (swap_go) begin
            state_q     <= ST_FILL;
            ready_q     <= 1'b1;
            held_q      <= 1'b1;
            done_q      <= 1'b1;
            wr_bank_q   <= ~wr_bank_q;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            peak_val_q  <= run_val_q;
            peak_idx_q  <= run_idx_q;
          end else begin
            state_q <= ST_STALL;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_FILL;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Remember which bank a read targeted so a later swap cannot redirect rd_data
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_sel_q <= 1'b0;
    end else if (rd_en) begin
      rd_sel_q <= ~wr_bank_q;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = xfer && (wr_bank_q == 1'(b));
    assign bank_re[b] = rd_en && (wr_bank_q != 1'(b));

    frame_bank_ram #(
      .DW    (W),
      .DEPTH (winS)
    ) u_ram (
      .clk_i   (Clk),
      .rst_i   (Rst),
      .we_i    (bank_we[b]),
      .waddr_i (wr_cnt_q),
      .wdata_i ($unsigned(in)),
      .re_i    (bank_re[b]),
      .raddr_i (rd_addr),
      .rdata_o (bank_rdata[b])
    );
  end

  assign rd_data    = $signed(rd_sel_q ? bank_rdata[1] : bank_rdata[0]);
  assign Ready_in   = ready_q;
  assign frame_done = done_q;
  assign peak_val   = peak_val_q;
  assign peak_idx   = peak_idx_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_capture_sink.sv
// Self-checking bench for frame_capture_sink (WI=WF=12, winS=8).
module tb_frame_capture_sink;

  localparam int WI = 12;
  localparam int WF = 12;
  localparam int W  = WI + WF;
  localparam int NS = 8;
  localparam int AW = 3;

  logic                  Clk = 1'b0;
  logic                  Rst;
  logic signed [W-1:0]   samp;
  logic                  Valid_in;
  logic                  Ready_in;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic signed [W-1:0]   rd_data;
  logic                  buf_release;
  logic                  frame_done;
  logic [W-1:0]          peak_val;
  logic [AW-1:0]         peak_idx;
  logic [15:0]           frame_cnt;

  always #5 Clk = ~Clk;

  frame_capture_sink #(.WI(WI), .WF(WF), .winS(NS)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .in          (samp),
    .Valid_in    (Valid_in),
    .Ready_in    (Ready_in),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .buf_release (buf_release),
    .frame_done  (frame_done),
    .peak_val    (peak_val),
    .peak_idx    (peak_idx),
    .frame_cnt   (frame_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [W-1:0] frame_s [NS];   // frame currently being sent
  logic [W-1:0] held_m  [NS];   // frame the host should see
  bit           held_m_v;
  int           cnt_m;
  logic [W-1:0] pk_val_m;
  int           pk_idx_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Peak from first principles: saturated magnitude, first index of the maximum
  function automatic void ref_peak();
    int best;
    int v;
    int a;
    best = -1;
    pk_idx_m = 0;
    for (int k = 0; k < NS; k++) begin
      v = $signed(frame_s[k]);
      a = (v < 0) ? -v : v;
      if (a > (1 << (W - 1)) - 1) a = (1 << (W - 1)) - 1;
      if (a > best) begin
        best = a;
        pk_idx_m = k;
      end
    end
    pk_val_m = best[W-1:0];
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(Ready_in), 32'd0);
    chk({tag, "_done"},  32'(frame_done), 32'd0);
    chk({tag, "_rd"},    {8'h00, rd_data}, 32'd0);
    chk({tag, "_pkval"}, {8'h00, peak_val}, 32'd0);
    chk({tag, "_pkidx"}, {29'h0, peak_idx}, 32'd0);
    chk({tag, "_cnt"},   {16'h0, frame_cnt}, 32'd0);
  endtask

  // Push frame_s; with gaps, Valid_in randomly drops between samples
  task automatic send_frame(input bit gaps);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < NS && guard < 200) begin
      guard++;
      buf_release = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        Valid_in = 1'b0;
        samp = W'($urandom);
        step();
      end else begin
        chk("ready_fill", 32'(Ready_in), 32'd1);
        samp = frame_s[k];
        Valid_in = 1'b1;
        step();
        k++;
      end
    end
    if (k < NS) chk("send_budget", 32'(k), 32'(NS));
    Valid_in = 1'b0;
  endtask

  // Swap edge: model takes the frame, outputs must show it in the frame_done cycle
  task automatic do_swap();
    step();
    buf_release = 1'b0;
    rd_en = 1'b0;
    for (int k = 0; k < NS; k++) held_m[k] = frame_s[k];
    held_m_v = 1'b1;
    cnt_m++;
    ref_peak();
    chk("swap_done",  32'(frame_done), 32'd1);
    chk("swap_ready", 32'(Ready_in), 32'd1);
    chk("swap_pkval", {8'h00, peak_val}, 32'(pk_val_m));
    chk("swap_pkidx", {29'h0, peak_idx}, 32'(pk_idx_m));
    chk("swap_cnt",   {16'h0, frame_cnt}, 32'(cnt_m & 16'hFFFF));
    step();
    chk("done_pulse", 32'(frame_done), 32'd0);
  endtask

  // Called right after the last transfer edge
  task automatic end_frame();
    chk("ready_swapcyc", 32'(Ready_in), 32'd0);
    chk("done_early",    32'(frame_done), 32'd0);
    if (!held_m_v) begin
      do_swap();
    end else begin
      step();
      chk("ready_stall", 32'(Ready_in), 32'd0);
      chk("done_stall",  32'(frame_done), 32'd0);
      chk("peak_hold",   {8'h00, peak_val}, 32'(pk_val_m));
    end
  endtask

  task automatic release_in_fill();
    buf_release = 1'b1;
    step();
    buf_release = 1'b0;
    held_m_v = 1'b0;
  endtask

  task automatic read_chk(input int addr);
    rd_en = 1'b1;
    rd_addr = AW'(addr);
    step();
    rd_en = 1'b0;
    chk("rd_data", {8'h00, rd_data}, {8'h00, held_m[addr]});
  endtask

  initial begin
    Rst = 1'b1;
    Valid_in = 1'b0;
    samp = '0;
    rd_en = 1'b0;
    rd_addr = '0;
    buf_release = 1'b0;
    held_m_v = 1'b0;
    cnt_m = 0;
    pk_val_m = '0;
    pk_idx_m = 0;

    // Reset state and Ready_in rising on the first edge after release
    step();
    step();
    chk_reset_outputs("rst");
    Rst = 1'b0;
    chk("ready_before_edge", 32'(Ready_in), 32'd0);
    step();
    chk("ready_rise", 32'(Ready_in), 32'd1);

    // Samples 1..8: peak 8 at index 7, first frame
    for (int k = 0; k < NS; k++) frame_s[k] = W'(k + 1);
    send_frame(1'b0);
    end_frame();
    for (int a = 0; a < NS; a++) read_chk(a);
    step();
    chk("rd_hold", {8'h00, rd_data}, {8'h00, held_m[NS-1]});

    // Tie on magnitude keeps first index
    release_in_fill();
    frame_s[0] = 24'd3;
    frame_s[1] = -24'sd5;
    frame_s[2] = 24'd5;
    for (int k = 3; k < NS; k++) frame_s[k] = 24'd0;
    send_frame(1'b1);
    end_frame();

    // Held frame not released: stall, Valid_in ignored, then release
    for (int k = 0; k < NS; k++) frame_s[k] = W'($urandom_range(0, 24'h3FFFFF));
    frame_s[$urandom_range(0, NS - 1)] = 24'h800000;
    send_frame(1'b0);
    end_frame();
    Valid_in = 1'b1;
    samp = 24'h123456;
    step();
    chk("stall_ready2", 32'(Ready_in), 32'd0);
    Valid_in = 1'b0;
    read_chk(1);
    buf_release = 1'b1;
    do_swap();
    chk("sat_peak", {8'h00, peak_val}, 32'h007FFFFF);

    // Read issued on the swap edge keeps the old held sample
    release_in_fill();
    for (int k = 0; k < NS; k++) frame_s[k] = W'(10 + k);
    send_frame(1'b0);
    end_frame();
    for (int k = 0; k < NS; k++) frame_s[k] = W'($urandom);
    send_frame(1'b1);
    end_frame();
    rd_en = 1'b1;
    rd_addr = 3'd3;
    buf_release = 1'b1;
    do_swap();
    chk("rd_across_swap", {8'h00, rd_data}, 32'd13);
    for (int k = 0; k < 4; k++) begin
      samp = W'($urandom);
      Valid_in = 1'b1;
      step();
    end
    Valid_in = 1'b0;
    chk("rd_after_overwrite", {8'h00, rd_data}, 32'd13);

    // Asynchronous reset mid-frame discards the partial frame
    #3 Rst = 1'b1;
    #1;
    cnt_m = 0;
    held_m_v = 1'b0;
    pk_val_m = '0;
    pk_idx_m = 0;
    chk_reset_outputs("midrst");
    step();
    Rst = 1'b0;
    chk("midrst_ready_low", 32'(Ready_in), 32'd0);
    step();
    chk("midrst_ready_rise", 32'(Ready_in), 32'd1);
    for (int k = 0; k < NS; k++) frame_s[k] = W'($urandom);
    send_frame(1'b1);
    end_frame();
    read_chk(int'($urandom_range(0, NS - 1)));

    // Random frames with random release behaviour
    for (int f = 0; f < 4; f++) begin
      bit was_held;
      if ($urandom_range(0, 1) == 1) release_in_fill();
      for (int k = 0; k < NS; k++) frame_s[k] = W'($urandom);
      was_held = held_m_v;
      send_frame(1'b1);
      end_frame();
      if (was_held) begin
        step();
        buf_release = 1'b1;
        do_swap();
      end
      read_chk(int'($urandom_range(0, NS - 1)));
      read_chk(int'($urandom_range(0, NS - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
